fifo_unpack: RTL
================

Name: fifo_unpack

Overview:
- Wide-to-narrow FIFO: accepts 32-bit words, each carrying a valid-nibble count, and delivers them to a consumer one 4-bit nibble per read.
- Partial words are supported; nibbles beyond a word's count are skipped on the read side.
- A flush handshake drains all buffered nibbles and then signals completion.
- Sits in front of a nibble-serial consumer as the narrowing counterpart of the team's nibble-to-word flush FIFO.

Parameters:
DEPTH, 4, number of 32-bit word entries (power of 2, >=2)
PTR_W, $clog2(DEPTH), row pointer width excluding wrap bit

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
fifo_wr_valid_i  input  1  write request for one word
fifo_wr_data_i  input  32  word; nibble i = bits [i*4+3:i*4], nibble 0 read first
fifo_wr_nibs_i  input  3  valid nibbles in word: 1..7 = that count, 0 = 8
fifo_wr_ovf_o  output  1  write request rejected this cycle
fifo_data_avail_o  output  1  at least one nibble readable
fifo_rd_valid_i  input  1  consume current nibble
fifo_rd_data_o  output  4  current nibble (combinational from storage)
fifo_flush_i  input  1  flush request, level
fifo_flush_done_o  output  1  one-cycle pulse: drain complete
fifo_empty_o  output  1  no words stored
fifo_full_o  output  1  DEPTH words stored

Behaviour:
- Storage: DEPTH entries, each {data[31:0], nibs[3:0]}; nibs is decoded count 1..8. Storage is not reset.
- Pointers: wr_ptr and rd_ptr are PTR_W+1 bits (wrap bit); rd_col is 3 bits.
- Reset values: pointers 0, rd_col 0, FSM IDLE.
  - Outputs at reset: empty_o=1, full_o=0, data_avail_o=0, flush_done_o=0, ovf_o=0.
- Flags, from registered pointers only:
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and wrap bits differ.
- Write acceptance:
  - A write is accepted when wr_valid_i & ~full & state!=DRAIN. The entry is stored at the clock edge and wr_ptr increments.
  - wr_valid_i while full, or while in DRAIN, is dropped; ovf_o=1 in that same cycle (combinational), otherwise 0.
- Read side:
  - data_avail_o = ~empty.
  - rd_data_o = mem[rd_ptr].data[rd_col*4 +: 4]. Its value is don't-care when empty.
- Read acceptance:
  - rd_valid_i & ~empty consumes a nibble.
  - If rd_col == nibs-1: rd_col <= 0 and rd_ptr increments. Otherwise rd_col increments.
  - rd_valid_i while empty is ignored: no pointer change, no error.
- Latency: a word written at edge N is readable in cycle N+1. A word of k nibbles needs exactly k reads.
- Simultaneous write and read are both performed. Full/empty use pre-edge pointers, so:
  - a write when full is rejected even if the last nibble of the oldest word is read in the same cycle;
  - a read when empty is ignored even if a write occurs in the same cycle.
- Wrap-around: pointers wrap naturally modulo 2*DEPTH; the row index is the low PTR_W bits.
- Flush FSM, with flush_q = registered fifo_flush_i:
  - IDLE: fifo_flush_i & ~flush_q (rising edge) -> DRAIN. A write in the rising-edge cycle is still accepted.
  - DRAIN: writes rejected, reads proceed normally. When empty (registered), flush_done_o=1 for that cycle, then -> DONE.
  - DONE: flush_done_o=0. When fifo_flush_i==0 -> IDLE; stay in DONE while it is held high.
  - Flush on an empty FIFO: flush_done_o pulses in the cycle after the rising edge.
  - Deassertion of fifo_flush_i during DRAIN does not abort the drain; the done pulse still occurs, then DONE -> IDLE on the next cycle.
- Reset asserted mid-operation (including mid-word or in DRAIN) discards everything and returns all state to reset values; no done pulse is produced.

Decomposition:
- Shared package fifo_pkg holds:
  - NIB_W=4, WORD_W=32, NIBS_PER_WORD=8;
  - typedef unpack_entry_t {data, nibs};
  - enum flush_state_e {IDLE, DRAIN, DONE};
  - function decode_nibs(3b) -> 4b (0 maps to 8).
- One natural sub-module: fifo_unpack_flush_fsm, containing flush_q edge detect, state register and done pulse. It takes empty as input and outputs wr_block and flush_done.

Test Plan:
- Full word: write 0x87654321 with nibs=0, then 8 reads -> rd_data 1,2,3,4,5,6,7,8; empty_o=1 after the 8th read.
- Partial word: write 0x000000A5 with nibs=2, then 0xFFFFFFF3 with nibs=1 -> reads return 5, A, 3; data_avail_o=0 after the 3rd read.
- Full/overflow: write 4 words with no reads -> full_o=1; 5th write -> ovf_o=1 and no state change. Read 8 nibbles and write in the same cycle as the last read -> write rejected; write on the next cycle -> accepted.
- Wrap: 10 write/drain rounds of nibs=3 words -> every word's 3 nibbles are correct across pointer wrap; full_o is never asserted.
- Flush with data: 2 words (nibs=4 each) stored, raise flush_i. A write in DRAIN -> ovf_o=1. 8 reads -> flush_done_o pulses exactly in the cycle empty_o first reads 1. Holding flush_i keeps the FSM in DONE; dropping it -> IDLE, and writes are accepted again.
- Empty flush and reset: flush_i rises with the FIFO empty -> done pulses in the next cycle. Separately, reset=0 mid-DRAIN -> empty_o=1, no done pulse, FSM in IDLE.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the word-to-nibble unpacking FIFO.
// The flush FSM state encoding is also used by the debug port and the bench.
package fifo_pkg;

  localparam int NIB_W         = 4;
  localparam int WORD_W        = 32;
  localparam int NIBS_PER_WORD = 8;

  // nibs holds the decoded count 1..8, so it needs one bit more than the port field
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [3:0]        nibs;
  } unpack_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

  // Port encoding uses 0 to mean a full word of 8 nibbles
  function automatic logic [3:0] decode_nibs(input logic [2:0] nibs_enc);
    logic [3:0] nibs_dec;
    if (nibs_enc == 3'd0) begin
      nibs_dec = 4'd8;
    end else begin
      nibs_dec = {1'b0, nibs_enc};
    end
    return nibs_dec;
  endfunction

endpackage

// File: rtl/fifo_unpack_flush_fsm.sv
// Flush sequencer: detects the flush request rising edge, blocks writes while
// draining and pulses flush_done for one cycle once the FIFO is empty.
module fifo_unpack_flush_fsm
  import fifo_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         empty_i,
  output logic         wr_block_o,
  output logic         flush_done_o,
  output flush_state_e state_o
);

  flush_state_e state_q, state_d;
  logic         flush_q, flush_d;
  logic         flush_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  assign flush_rise = flush_i & ~flush_q;

  always_comb begin
    state_d      = state_q;
    flush_d      = flush_i;
    wr_block_o   = 1'b0;
    flush_done_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_rise) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Dropping flush_i here does not abort; the drain always completes
        wr_block_o = 1'b1;
        if (empty_i) begin
          flush_done_o = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (!flush_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/fifo_unpack.sv
// Wide-to-narrow FIFO: stores 32-bit words with a valid-nibble count and
// returns them one nibble per read, nibble 0 first, skipping unused nibbles.
module fifo_unpack
  import fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_wr_valid_i,
  input  logic [WORD_W-1:0] fifo_wr_data_i,
  input  logic [2:0]        fifo_wr_nibs_i,
  output logic              fifo_wr_ovf_o,
  output logic              fifo_data_avail_o,
  input  logic              fifo_rd_valid_i,
  output logic [NIB_W-1:0]  fifo_rd_data_o,
  input  logic              fifo_flush_i,
  output logic              fifo_flush_done_o,
  output logic              fifo_empty_o,
  output logic              fifo_full_o,
  output flush_state_e      fifo_flush_state_o
);

  // Handshake: there is no ready. A write is taken when wr_valid is high and the
  // FIFO is neither full nor draining, else ovf flags the drop in the same cycle;
  // a read consumes the shown nibble when rd_valid is high and the FIFO is non-empty.

  unpack_entry_t    mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]       rd_col_q, rd_col_d;

  logic             empty;
  logic             full;
  logic             wr_block;
  logic             wr_accept;
  logic             rd_accept;
  logic             rd_last;
  unpack_entry_t    rd_entry;
  unpack_entry_t    wr_entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_col_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_col_q <= rd_col_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_entry;
    end
  end

  // Flags come from registered pointers only, so same-cycle traffic never
  // relieves a full or empty condition
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                 (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

  assign wr_entry.data = fifo_wr_data_i;
  assign wr_entry.nibs = decode_nibs(fifo_wr_nibs_i);

  assign rd_entry = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign wr_accept = fifo_wr_valid_i & ~full & ~wr_block;
  assign rd_accept = fifo_rd_valid_i & ~empty;
  assign rd_last   = ({1'b0, rd_col_q} == (rd_entry.nibs - 4'd1));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd_col_d = rd_col_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      if (rd_last) begin
        rd_col_d = '0;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        rd_col_d = rd_col_q + 3'd1;
      end
    end
  end

  fifo_unpack_flush_fsm u_flush_fsm (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (fifo_flush_i),
    .empty_i      (empty),
    .wr_block_o   (wr_block),
    .flush_done_o (fifo_flush_done_o),
    .state_o      (fifo_flush_state_o)
  );

  assign fifo_wr_ovf_o     = fifo_wr_valid_i & ~wr_accept;
  assign fifo_data_avail_o = ~empty;
  assign fifo_rd_data_o    = rd_entry.data[{rd_col_q, 2'b00} +: NIB_W];
  assign fifo_empty_o      = empty;
  assign fifo_full_o       = full;

endmodule
